// File: rtl/spu_pkg.sv
// +-----------------------------------------------------------------------+
// | spu_pkg                                                               |
// | Shared formats, opcodes and helpers for the SPU permute unit.         |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

package spu_pkg;

  typedef enum logic [2:0] {
    FMT_RR  = 3'd0,
    FMT_RI7 = 3'd2
  } spu_fmt_e;

  // RR opcodes, MSB-aligned in the 11-bit opcode field
  localparam logic [0:10] OP_SHLQBI   = 11'b00111011011;
  localparam logic [0:10] OP_SHLQBY   = 11'b00111011111;
  localparam logic [0:10] OP_SHLQBYBI = 11'b00111001111;
  localparam logic [0:10] OP_ROTQBI   = 11'b00111011000;
  localparam logic [0:10] OP_ROTQBY   = 11'b00111011100;
  localparam logic [0:10] OP_ROTQBYBI = 11'b00111001100;
  localparam logic [0:10] OP_ROTQMBI  = 11'b00111011001;
  localparam logic [0:10] OP_ROTQMBY  = 11'b00111011101;
  localparam logic [0:10] OP_GBB      = 11'b00110110010;
  localparam logic [0:10] OP_GBH      = 11'b00110110001;
  localparam logic [0:10] OP_GB       = 11'b00110110000;

  // RI7 opcodes occupy the full 11-bit opcode field
  localparam logic [0:10] OP_SHLQBII  = 11'b00111111011;
  localparam logic [0:10] OP_SHLQBYI  = 11'b00111111111;
  localparam logic [0:10] OP_ROTQBII  = 11'b00111111000;
  localparam logic [0:10] OP_ROTQBYI  = 11'b00111111100;
  localparam logic [0:10] OP_ROTQMBII = 11'b00111111001;
  localparam logic [0:10] OP_ROTQMBYI = 11'b00111111101;

  typedef struct packed {
    logic [0:127] rt;
    logic [0:6]   addr;
    logic         we;
  } spu_slot_t;

  // Rotate left (towards bit 0) by n bits, n in 0..127
  function automatic logic [0:127] rotl128(input logic [0:127] v, input logic [7:0] n);
    logic [0:255] d;
    d = {v, v};
    return d[n +: 128];
  endfunction

endpackage

`default_nettype wire

// File: rtl/spu_perm_alu.sv
// +-----------------------------------------------------------------------+
// | spu_perm_alu                                                          |
// | Combinational quadword shift/rotate/gather datapath.                  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module spu_perm_alu
  import spu_pkg::*;
(
  input  logic [0:10]  op,
  input  logic [2:0]   format,
  input  logic [0:127] ra,
  input  logic [0:127] rb,
  input  logic [0:17]  imm,
  output logic [0:127] result,
  output logic         valid
);

  logic [2:0] rr_bits;
  logic [4:0] rr_bytes;
  logic [4:0] rr_bytes_bi;
  logic [3:0] rr_rot;
  logic [3:0] rr_rot_bi;
  logic [2:0] ri_bits;
  logic [4:0] ri_bytes;
  logic [2:0] rr_neg_bits;
  logic [4:0] rr_neg_bytes;
  logic [2:0] ri_neg_bits;
  logic [4:0] ri_neg_bytes;
  logic       unused_bits;

  assign rr_bits      = rb[29:31];
  assign rr_bytes     = rb[27:31];
  assign rr_bytes_bi  = rb[24:28];
  assign rr_rot       = rb[28:31];
  assign rr_rot_bi    = rb[25:28];
  assign ri_bits      = imm[15:17];
  assign ri_bytes     = imm[13:17];
  assign rr_neg_bits  = 3'd0 - rr_bits;
  assign rr_neg_bytes = 5'd0 - rr_bytes;
  assign ri_neg_bits  = 3'd0 - ri_bits;
  assign ri_neg_bytes = 5'd0 - ri_bytes;
  assign unused_bits  = ^{rb[0:23], rb[32:127], imm[0:12]};

  // Byte shifts use an 8-bit amount so counts of 16+ bytes naturally clear the result
  always_comb begin
    result = '0;
    valid  = 1'b0;
    if (format == FMT_RR) begin
      valid = 1'b1;
      case (op)
        OP_SHLQBI:   result = ra << rr_bits;
        OP_SHLQBY:   result = ra << {rr_bytes, 3'b000};
        OP_SHLQBYBI: result = ra << {rr_bytes_bi, 3'b000};
        OP_ROTQBI:   result = rotl128(ra, {5'd0, rr_bits});
        OP_ROTQBY:   result = rotl128(ra, {1'b0, rr_rot, 3'b000});
        OP_ROTQBYBI: result = rotl128(ra, {1'b0, rr_rot_bi, 3'b000});
        OP_ROTQMBI:  result = ra >> rr_neg_bits;
        OP_ROTQMBY:  result = ra >> {rr_neg_bytes, 3'b000};
        OP_GBB:      for (int i = 0; i < 16; i++) result[16 + i] = ra[8 * i + 7];
        OP_GBH:      for (int i = 0; i < 8; i++)  result[24 + i] = ra[16 * i + 15];
        OP_GB:       for (int i = 0; i < 4; i++)  result[28 + i] = ra[32 * i + 31];
        default:     valid = 1'b0;
      endcase
    end else if (format == FMT_RI7) begin
      valid = 1'b1;
      case (op)
        OP_SHLQBII:  result = ra << ri_bits;
        OP_SHLQBYI:  result = ra << {ri_bytes, 3'b000};
        OP_ROTQBII:  result = rotl128(ra, {5'd0, ri_bits});
        OP_ROTQBYI:  result = rotl128(ra, {1'b0, ri_bytes[3:0], 3'b000});
        OP_ROTQMBII: result = ra >> ri_neg_bits;
        OP_ROTQMBYI: result = ra >> {ri_neg_bytes, 3'b000};
        default:     valid = 1'b0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/spu_permute_unit.sv
// +-----------------------------------------------------------------------+
// | spu_permute_unit                                                      |
// | Odd-pipe permute/shift unit: datapath plus 3-stage result pipeline.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module spu_permute_unit
  import spu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [0:10]  op,
  input  logic [2:0]   format,
  input  logic [0:6]   rt_addr,
  input  logic [0:127] ra,
  input  logic [0:127] rb,
  input  logic [0:17]  imm,
  input  logic         reg_write,
  output logic [0:127] rt_wb,
  output logic [0:6]   rt_addr_wb,
  output logic         reg_write_wb
);

  logic [0:127] alu_result;
  logic         alu_valid;
  spu_slot_t    s1, s2, s3;

  spu_perm_alu u_alu (
    .op     (op),
    .format (format),
    .ra     (ra),
    .rb     (rb),
    .imm    (imm),
    .result (alu_result),
    .valid  (alu_valid)
  );

  // Unrecognised slots still carry their address but never request a write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1.rt   <= alu_result;
      s1.addr <= rt_addr;
      s1.we   <= alu_valid & reg_write;
      s2      <= s1;
      s3      <= s2;
    end
  end

  assign rt_wb        = s3.rt;
  assign rt_addr_wb   = s3.addr;
  assign reg_write_wb = s3.we;

endmodule

`default_nettype wire

// File: tb/tb_spu_permute_unit.sv
// +-----------------------------------------------------------------------+
// | tb_spu_permute_unit                                                   |
// | Directed self-checking bench for spu_permute_unit.                    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_spu_permute_unit;

  logic         clk;
  logic         reset;
  logic [0:10]  op;
  logic [2:0]   format;
  logic [0:6]   rt_addr;
  logic [0:127] ra;
  logic [0:127] rb;
  logic [0:17]  imm;
  logic         reg_write;
  logic [0:127] rt_wb;
  logic [0:6]   rt_addr_wb;
  logic         reg_write_wb;

  int checks = 0;
  int errors = 0;

  localparam logic [0:127] SEQ = 128'h0102030405060708090A0B0C0D0E0F10;
  localparam logic [0:127] MSB = 128'h80000000000000000000000000000000;
  localparam logic [0:127] ONES = {128{1'b1}};

  spu_permute_unit dut (
    .clk          (clk),
    .reset        (reset),
    .op           (op),
    .format       (format),
    .rt_addr      (rt_addr),
    .ra           (ra),
    .rb           (rb),
    .imm          (imm),
    .reg_write    (reg_write),
    .rt_wb        (rt_wb),
    .rt_addr_wb   (rt_addr_wb),
    .reg_write_wb (reg_write_wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [0:10] o, input logic [2:0] f, input logic [0:6] a,
                       input logic [0:127] x, input logic [0:127] y, input logic [0:17] i,
                       input logic w);
    op = o; format = f; rt_addr = a; ra = x; rb = y; imm = i; reg_write = w;
  endtask

  task automatic clear_inputs();
    drive(11'd0, 3'd0, 7'd0, '0, '0, 18'd0, 1'b0);
  endtask

  // One instruction in an otherwise empty pipe; returns #1 after its third edge
  task automatic issue(input logic [0:10] o, input logic [2:0] f, input logic [0:6] a,
                       input logic [0:127] x, input logic [0:127] y, input logic [0:17] i,
                       input logic w);
    @(negedge clk);
    drive(o, f, a, x, y, i, w);
    @(posedge clk); #1;
    clear_inputs();
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(11'b00111011011, 3'd0, 7'd3, {8{16'h0001}}, {32'h00010001, 96'h0}, 18'd0, 1'b1);
    #8;
    check("reset_rt", rt_wb, '0);
    check("reset_addr", {121'd0, rt_addr_wb}, 128'd0);
    check("reset_we", {127'd0, reg_write_wb}, 128'd0);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("latency_rt", rt_wb, '0);
    @(posedge clk); #1;
    check("shlqbi_rt", rt_wb, {8{16'h0002}});
    check("shlqbi_addr", {121'd0, rt_addr_wb}, 128'd3);
    check("shlqbi_we", {127'd0, reg_write_wb}, 128'd1);

    issue(11'b00111011000, 3'd0, 7'd5, 128'hBFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFE,
          {32'h00010011, 96'h0}, 18'd0, 1'b1);
    check("rotqbi_rt", rt_wb, 128'h7FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFD);
    check("rotqbi_addr", {121'd0, rt_addr_wb}, 128'd5);
    check("rotqbi_we", {127'd0, reg_write_wb}, 128'd1);

    issue(11'b00110110010, 3'd0, 7'd6, 128'hCEEFCACEAFBFCFDFABCDEFABCDEFFEEE, '0, 18'd0, 1'b1);
    check("gbb_rt", rt_wb, 128'h00004FFC000000000000000000000000);

    issue(11'b00111111100, 3'd2, 7'd7, 128'hCEEFFFFFFFFFFFFFFFFFFFFFFFFFFEEE, '0, 18'd3, 1'b1);
    check("rotqbyi_rt", rt_wb, 128'hFFFFFFFFFFFFFFFFFFFFFFFEEECEEFFF);

    issue(11'b00111011111, 3'd0, 7'd8, ONES, {32'h00000010, 96'h0}, 18'd0, 1'b1);
    check("shlqby16_rt", rt_wb, '0);
    check("shlqby16_we", {127'd0, reg_write_wb}, 128'd1);

    issue(11'd0, 3'd0, 7'd9, ONES, ONES, 18'd0, 1'b1);
    check("nop_rt", rt_wb, '0);
    check("nop_addr", {121'd0, rt_addr_wb}, 128'd9);
    check("nop_we", {127'd0, reg_write_wb}, 128'd0);

    issue(11'b00111011001, 3'd0, 7'd10, MSB, {32'h00000007, 96'h0}, 18'd0, 1'b1);
    check("rotqmbi_rt", rt_wb, 128'h40000000000000000000000000000000);

    issue(11'b00111011101, 3'd0, 7'd11, SEQ, {32'h0000001E, 96'h0}, 18'd0, 1'b1);
    check("rotqmby_rt", rt_wb, 128'h00000102030405060708090A0B0C0D0E);

    issue(11'b00110110001, 3'd0, 7'd12, 128'h00010000000100010000000000010001, '0, 18'd0, 1'b1);
    check("gbh_rt", rt_wb, 128'h000000B3000000000000000000000000);

    issue(11'b00110110000, 3'd0, 7'd13, 128'h00000001000000000000000300000002, '0, 18'd0, 1'b1);
    check("gb_rt", rt_wb, 128'h0000000A000000000000000000000000);

    issue(11'b00111001111, 3'd0, 7'd14, SEQ, {32'h00000010, 96'h0}, 18'd0, 1'b1);
    check("shlqbybi_rt", rt_wb, 128'h030405060708090A0B0C0D0E0F100000);

    issue(11'b00111001100, 3'd0, 7'd15, SEQ, {32'h00000088, 96'h0}, 18'd0, 1'b1);
    check("rotqbybi_rt", rt_wb, 128'h02030405060708090A0B0C0D0E0F1001);

    issue(11'b00111011100, 3'd0, 7'd16, SEQ, {32'h00000013, 96'h0}, 18'd0, 1'b1);
    check("rotqby_rt", rt_wb, 128'h0405060708090A0B0C0D0E0F10010203);

    issue(11'b00111111111, 3'd2, 7'd17, ONES, '0, 18'h00011, 1'b1);
    check("shlqbyi17_rt", rt_wb, '0);
    check("shlqbyi17_we", {127'd0, reg_write_wb}, 128'd1);

    issue(11'b00111111001, 3'd2, 7'd18, MSB, '0, 18'h0007D, 1'b1);
    check("rotqmbii_rt", rt_wb, 128'h10000000000000000000000000000000);

    issue(11'b00111111101, 3'd2, 7'd19, SEQ, '0, 18'h0007F, 1'b1);
    check("rotqmbyi_rt", rt_wb, 128'h000102030405060708090A0B0C0D0E0F);

    issue(11'b00111011011, 3'd1, 7'd20, ONES, {32'h00000001, 96'h0}, 18'd0, 1'b1);
    check("badfmt_rt", rt_wb, '0);
    check("badfmt_we", {127'd0, reg_write_wb}, 128'd0);

    // Back-to-back slots: rotqbi then gb with reg_write low
    @(negedge clk);
    drive(11'b00111011000, 3'd0, 7'd1, 128'h80000000000000000000000000000001,
          {32'h00000002, 96'h0}, 18'd0, 1'b1);
    @(posedge clk); #1;
    drive(11'b00110110000, 3'd0, 7'd2, 128'h00000001000000000000000300000002, '0, 18'd0, 1'b0);
    @(posedge clk); #1;
    clear_inputs();
    @(posedge clk); #1;
    check("b2b_a_rt", rt_wb, 128'h6);
    check("b2b_a_addr", {121'd0, rt_addr_wb}, 128'd1);
    check("b2b_a_we", {127'd0, reg_write_wb}, 128'd1);
    @(posedge clk); #1;
    check("b2b_b_rt", rt_wb, 128'h0000000A000000000000000000000000);
    check("b2b_b_addr", {121'd0, rt_addr_wb}, 128'd2);
    check("b2b_b_we", {127'd0, reg_write_wb}, 128'd0);

    // Asynchronous reset while an instruction is in flight
    @(negedge clk);
    drive(11'b00111011011, 3'd0, 7'd4, {8{16'h0001}}, {32'h00000001, 96'h0}, 18'd0, 1'b1);
    @(posedge clk); #1;
    clear_inputs();
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    check("flush_async_we", {127'd0, reg_write_wb}, 128'd0);
    check("flush_async_rt", rt_wb, '0);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("flush_slot_we", {127'd0, reg_write_wb}, 128'd0);
    check("flush_slot_rt", rt_wb, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
